// File: rtl/counter_pkg.sv
// Shared definitions for the 8-bit parallel-load counter and its sequencing controller.
package counter_pkg;

   localparam int CNT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } timer_state_t;

endpackage

// File: rtl/counter_timer_ctrl.sv
// Timer sequencer: loads a start value into the downstream counter, reloads it on every
// carry-out, counts elapsed periods and pulses done after the last one.
module counter_timer_ctrl
   import counter_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH,
   parameter int PER_W = 8
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [WIDTH-1:0] cmd_start_i,
   input  logic [PER_W-1:0] cmd_periods_i,
   input  logic             abort_i,
   input  logic [WIDTH-1:0] cnt_q_i,
   input  logic             cnt_cout_i,
   output logic             cnt_load_o,
   output logic [WIDTH-1:0] cnt_data_o,
   output logic             cnt_hold_o,
   output logic             tick_o,
   output logic             done_o,
   output logic             busy_o,
   output logic [PER_W-1:0] remaining_o,
   output logic [1:0]       state_o
);

   // Handshake: a command transfers on any rising edge where cmd_valid_i and cmd_ready_o
   // are both high; ready is only high in IDLE and never depends on cmd_valid_i.

   timer_state_t     state_q, state_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [PER_W-1:0] remaining_q, remaining_d;
   logic             ready_q, hold_q, busy_q, done_q, load_q;
   logic             abort_act, run_cout;
   logic             unused_cnt;

   // The counter value is status only; nothing in the sequencing depends on it.
   assign unused_cnt = ^cnt_q_i;

   assign abort_act = abort_i & ((state_q == LOAD) | (state_q == RUN));
   assign run_cout  = (state_q == RUN) & cnt_cout_i & ~abort_i;

   always_comb begin
      state_d     = state_q;
      start_d     = start_q;
      remaining_d = remaining_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid_i & ready_q) begin
               start_d     = cmd_start_i;
               remaining_d = cmd_periods_i;
               state_d     = (cmd_periods_i == '0) ? DONE : LOAD;
            end
         end
         LOAD: state_d = RUN;
         RUN: begin
            if (cnt_cout_i) begin
               remaining_d = remaining_q - PER_W'(1);
               if (remaining_q == PER_W'(1)) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Abort wins over a coincident carry-out.
      if (abort_act) begin
         state_d     = IDLE;
         remaining_d = '0;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= IDLE;
         start_q     <= '0;
         remaining_q <= '0;
         ready_q     <= 1'b1;
         hold_q      <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         load_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_q     <= start_d;
         remaining_q <= remaining_d;
         ready_q     <= (state_d == IDLE);
         hold_q      <= (state_d == IDLE) | (state_d == DONE);
         busy_q      <= (state_d == LOAD) | (state_d == RUN);
         done_q      <= (state_d == DONE);
         load_q      <= (state_d == LOAD);
      end
   end

   // Reloading on carry-out makes the counter restart at S instead of wrapping to 0.
   assign cnt_load_o  = (load_q & ~abort_i) | run_cout;
   assign tick_o      = run_cout;
   assign cnt_data_o  = start_q;
   assign cnt_hold_o  = hold_q;
   assign cmd_ready_o = ready_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign remaining_o = remaining_q;
   assign state_o     = state_q;

endmodule

// File: doc/counter_timer_ctrl.md
# counter_timer_ctrl

Sequencing controller that sits directly upstream of the 8-bit parallel-load counter and drives its load, data and count-enable inputs. It accepts a timer command over a valid/ready handshake and loads the start value into the counter. It lets the counter run, reloads it on every carry-out, counts the elapsed periods and signals completion. Downstream logic consumes the per-period `tick_o` and the one-cycle `done_o`.

## Interface
Parameters:
- `WIDTH`, 8: counter data width; must match the counter.
- `PER_W`, 8: width of the period count.

Ports:
- `Clk` in 1: clock; all state updates on the rising edge.
- `Rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid_i` in 1: command present.
- `cmd_ready_o` out 1: controller can accept a command.
- `cmd_start_i` in WIDTH: counter reload value S.
- `cmd_periods_i` in PER_W: number of periods N to run.
- `abort_i` in 1: cancel the running command.
- `cnt_q_i` in WIDTH: counter output `data_o`; status only.
- `cnt_cout_i` in 1: counter `cout`. It is high when the counter is at all-ones and counting.
- `cnt_load_o` out 1: drives the counter `load_i`.
- `cnt_data_o` out WIDTH: drives the counter `data_i`.
- `cnt_hold_o` out 1: drives the counter `d_i`. 1 = hold, 0 = increment.
- `tick_o` out 1: one-cycle pulse per completed period.
- `done_o` out 1: one-cycle pulse when all N periods have completed.
- `busy_o` out 1: high in LOAD or RUN.
- `remaining_o` out PER_W: periods still to run.

## Operation
- FSM states are IDLE, LOAD, RUN and DONE.
- **IDLE**
  - Outputs: `cmd_ready_o`=1, `cnt_hold_o`=1, `cnt_load_o`=0.
  - On `cmd_valid_i & cmd_ready_o`, latch S into `start_q` (drives `cnt_data_o`) and N into `remaining_o`.
  - Next state is LOAD. If N=0, next state is DONE directly.
- **LOAD**
  - Outputs: `cnt_load_o`=1, `cnt_hold_o`=0.
  - The counter holds S after the edge. Next state is RUN.
- **RUN**
  - Outputs: `cnt_hold_o`=0, and `cnt_load_o` = `cnt_cout_i` (combinational).
  - The counter therefore reloads S instead of wrapping to 0.
  - `tick_o` = `cnt_cout_i`.
  - On `cnt_cout_i`, `remaining_o` decrements.
  - If `remaining_o`==1 at that point, the next state is DONE; otherwise stay in RUN.
- **DONE**
  - Outputs: `done_o`=1, `cnt_hold_o`=1. The counter is parked at S.
  - Next state is IDLE.
- **Abort**
  - `abort_i` in LOAD or RUN: next state is IDLE.
  - `tick_o` and `cnt_load_o` are forced to 0 that cycle and `remaining_o` is cleared.
  - No `done_o` is issued.
  - `abort_i` is ignored in IDLE and DONE.
- Period length is 2^WIDTH − S cycles. S = all-ones gives a tick every RUN cycle.
- `remaining_o` decrement wraps never; RUN is exited before it reaches 0.

## Timing
- Reset values:
  - State IDLE.
  - `cmd_ready_o`=1, `cnt_hold_o`=1.
  - `cnt_load_o`=0, `tick_o`=0, `done_o`=0, `busy_o`=0.
  - `cnt_data_o`=0, `remaining_o`=0.
- Reset mid-RUN: the asynchronous return to IDLE holds the counter immediately. No done or tick is issued.
- Command accepted at edge k: LOAD in cycle k+1, and the counter equals S in cycle k+2, the first RUN cycle.
- First tick occurs in RUN cycle index 2^WIDTH−1−S (0-based). Subsequent ticks follow every 2^WIDTH−S cycles.
- `done_o` is high in the cycle after the final tick. `cmd_ready_o` is high the cycle after that.
- `cmd_ready_o` is low in LOAD, RUN and DONE; commands presented then are not accepted.
- `tick_o` and RUN-state `cnt_load_o` are combinational from `cnt_cout_i`. All other outputs are registered or state-decoded.
- Simultaneous `abort_i` and `cnt_cout_i`: abort wins.

## Structure
- Shared package `counter_pkg` holds:
  - the state enum `timer_state_t` (IDLE, LOAD, RUN, DONE);
  - the `CNT_WIDTH`=8 constant, shared with the counter block.
- Single module with no sub-module. The period down-counter and the `start_q` register are inline.

## Test plan
- Command S=0xFC, N=2 accepted at cycle 0:
  - LOAD at 1; `cnt_q_i` follows 0xFC,FD,FE,FF in cycles 2–5;
  - `tick_o` at 5 and 9; `done_o` at 10; `cmd_ready_o` at 11;
  - counter parked at 0xFC.
- S=0xFF, N=3: tick in three consecutive RUN cycles, then `done_o`; `remaining_o` steps 3→2→1.
- N=0: accepted, DONE next cycle, `done_o` pulse, no `cnt_load_o` or `tick_o`.
- S=0xF0, N=5, with `abort_i` in the same cycle as the 2nd `cnt_cout_i`:
  - no tick that cycle, no `done_o`;
  - IDLE next cycle with `cnt_hold_o`=1 and `remaining_o`=0.
- `Rst_n` low mid-RUN: all outputs go to reset values immediately; `cmd_valid_i` held high during RUN is not accepted until IDLE.
